// File: rtl/ctrl_pkg.sv
// Shared decode constants and the ID/EX control bundle for the MIPS-subset pipeline.
package ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;

    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_XOR   = 6'b100110;
    localparam logic [5:0] FN_NOR   = 6'b100111;
    localparam logic [5:0] FN_SLT   = 6'b101010;

    localparam logic [2:0] ALU_AND  = 3'b000;
    localparam logic [2:0] ALU_OR   = 3'b001;
    localparam logic [2:0] ALU_ADD  = 3'b010;
    localparam logic [2:0] ALU_XOR  = 3'b011;
    localparam logic [2:0] ALU_NOR  = 3'b100;
    localparam logic [2:0] ALU_SUB  = 3'b110;
    localparam logic [2:0] ALU_SLT  = 3'b111;

    typedef struct packed {
        logic       reg_write;
        logic       reg_dst;
        logic       branch;
        logic       branch_ne;
        logic       mem_read;
        logic       mem_write;
        logic       alu_src_b;
        logic       mem_to_reg;
        logic [2:0] alu_code;
    } ctrl_t;

    localparam int    CTRL_W       = $bits(ctrl_t);
    localparam ctrl_t CTRL_NONE    = '0;
    // Unknown encodings still flow down the pipe; only the ALU default is set.
    localparam ctrl_t CTRL_ILLEGAL = '{alu_code: ALU_ADD, default: 1'b0};

endpackage

// File: rtl/ctrl_decode.sv
// Combinational instruction decode: inst -> control bundle, illegal flag and
// whether the instruction reads rt as a source operand.
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [31:0]       inst,
    output logic [CTRL_W-1:0] ctrl,
    output logic              illegal,
    output logic              rt_src
);

    logic [5:0] op;
    logic [5:0] fn;
    ctrl_t      c;

    assign op = inst[31:26];
    assign fn = inst[5:0];

    always_comb begin
        c       = CTRL_NONE;
        illegal = 1'b0;
        rt_src  = 1'b0;
        if (inst != 32'd0) begin
            unique case (op)
                OP_RTYPE: begin
                    c.reg_write = 1'b1;
                    c.reg_dst   = 1'b1;
                    rt_src      = 1'b1;
                    unique case (fn)
                        FN_ADD:  c.alu_code = ALU_ADD;
                        FN_SUB:  c.alu_code = ALU_SUB;
                        FN_AND:  c.alu_code = ALU_AND;
                        FN_OR:   c.alu_code = ALU_OR;
                        FN_XOR:  c.alu_code = ALU_XOR;
                        FN_NOR:  c.alu_code = ALU_NOR;
                        FN_SLT:  c.alu_code = ALU_SLT;
                        default: begin
                            c       = CTRL_ILLEGAL;
                            illegal = 1'b1;
                            rt_src  = 1'b0;
                        end
                    endcase
                end
                OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI: begin
                    c.reg_write = 1'b1;
                    c.alu_src_b = 1'b1;
                    unique case (op)
                        OP_ANDI: c.alu_code = ALU_AND;
                        OP_ORI:  c.alu_code = ALU_OR;
                        OP_XORI: c.alu_code = ALU_XOR;
                        OP_SLTI: c.alu_code = ALU_SLT;
                        default: c.alu_code = ALU_ADD;
                    endcase
                end
                OP_LW: begin
                    c.reg_write  = 1'b1;
                    c.alu_src_b  = 1'b1;
                    c.mem_read   = 1'b1;
                    c.mem_to_reg = 1'b1;
                    c.alu_code   = ALU_ADD;
                end
                OP_SW: begin
                    c.alu_src_b = 1'b1;
                    c.mem_write = 1'b1;
                    c.alu_code  = ALU_ADD;
                    rt_src      = 1'b1;
                end
                OP_BEQ, OP_BNE: begin
                    c.branch    = 1'b1;
                    c.branch_ne = (op == OP_BNE);
                    c.alu_code  = ALU_SUB;
                    rt_src      = 1'b1;
                end
                default: begin
                    c       = CTRL_ILLEGAL;
                    illegal = 1'b1;
                end
            endcase
        end
    end

    assign ctrl = c;

endmodule

// File: rtl/id_ex_ctrl.sv
// ID/EX pipeline stage: decode, load-use hazard detection, bubble/flush control.
// Optional perf counters (stall_cnt, flush_cnt) enabled by ID_EX_PERF_CNT_EN.
module id_ex_ctrl
    import ctrl_pkg::*;
#(
    parameter int ALUCODE_W = 3,
    parameter int REG_W     = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [31:0]          inst,
    input  logic                 id_valid,
    input  logic                 flush,
    output logic                 stall,
    output logic                 ex_valid,
    output logic                 ex_RegWrite,
    output logic                 ex_RegDst,
    output logic                 ex_Branch,
    output logic                 ex_BranchNe,
    output logic                 ex_MemRead,
    output logic                 ex_MemWrite,
    output logic                 ex_ALUSrc_B,
    output logic                 ex_MemtoReg,
    output logic [ALUCODE_W-1:0] ex_ALUCode,
    output logic [REG_W-1:0]     ex_rs,
    output logic [REG_W-1:0]     ex_rt,
    output logic [REG_W-1:0]     ex_rd,
    output logic [31:0]          ex_imm,
    output logic                 ex_illegal
`ifdef ID_EX_PERF_CNT_EN
    ,
    output logic [31:0]          stall_cnt,
    output logic [31:0]          flush_cnt
`endif
);

    logic [CTRL_W-1:0] dec_bits;
    ctrl_t             dec;
    logic              dec_illegal;
    logic              dec_rt_src;
    ctrl_t             ex_ctrl;
    logic              hazard;
    logic              bubble;

    ctrl_decode u_dec (
        .inst    (inst),
        .ctrl    (dec_bits),
        .illegal (dec_illegal),
        .rt_src  (dec_rt_src)
    );

    assign dec = ctrl_t'(dec_bits);

    // Only a load already in EX can hazard; a bubble there never stalls.
    assign hazard = id_valid & ex_valid & ex_ctrl.mem_read & (ex_rt != '0) &
                    ((ex_rt == REG_W'(inst[25:21])) |
                     (dec_rt_src & (ex_rt == REG_W'(inst[20:16]))));

    assign stall  = rst_n & hazard & ~flush;
    assign bubble = flush | stall | ~id_valid;

    always_ff @(posedge clk) begin
        if (!rst_n || bubble) begin
            ex_valid   <= 1'b0;
            ex_ctrl    <= CTRL_NONE;
            ex_illegal <= 1'b0;
            ex_rs      <= '0;
            ex_rt      <= '0;
            ex_rd      <= '0;
            ex_imm     <= '0;
        end else begin
            ex_valid   <= 1'b1;
            ex_ctrl    <= dec;
            ex_illegal <= dec_illegal;
            ex_rs      <= REG_W'(inst[25:21]);
            ex_rt      <= REG_W'(inst[20:16]);
            ex_rd      <= REG_W'(inst[15:11]);
            ex_imm     <= {{16{inst[15]}}, inst[15:0]};
        end
    end

    assign ex_RegWrite = ex_ctrl.reg_write;
    assign ex_RegDst   = ex_ctrl.reg_dst;
    assign ex_Branch   = ex_ctrl.branch;
    assign ex_BranchNe = ex_ctrl.branch_ne;
    assign ex_MemRead  = ex_ctrl.mem_read;
    assign ex_MemWrite = ex_ctrl.mem_write;
    assign ex_ALUSrc_B = ex_ctrl.alu_src_b;
    assign ex_MemtoReg = ex_ctrl.mem_to_reg;
    assign ex_ALUCode  = ALUCODE_W'(ex_ctrl.alu_code);

`ifdef ID_EX_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall && stall_cnt != 32'hFFFF_FFFF)
                stall_cnt <= stall_cnt + 32'd1;
            if (flush && flush_cnt != 32'hFFFF_FFFF)
                flush_cnt <= flush_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: doc/id_ex_ctrl.md
ID_EX_CTRL -- requirements
Module: id_ex_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset: clk  in  1  rising-edge clock; rst_n  in  1  synchronous active-low reset.
REQ-002 Parameters SHALL be: ALUCODE_W, default 3, ALUCode width (>=3, codes zero-extended); REG_W, default 5, register-address width.
REQ-003 Ports SHALL be: inst  in  32  IF/ID instruction; id_valid  in  1  IF/ID slot holds a real instruction; flush  in  1  branch taken, kill ID/EX.
REQ-004 Outputs SHALL be: stall  out  1  hold PC and IF/ID; ex_valid  out  1; ex_RegWrite, ex_RegDst, ex_Branch, ex_BranchNe, ex_MemRead, ex_MemWrite, ex_ALUSrc_B, ex_MemtoReg  out  1 each; ex_ALUCode  out  ALUCODE_W; ex_rs, ex_rt, ex_rd  out  REG_W; ex_imm  out  32  sign-extended inst[15:0]; ex_illegal  out  1.

Function
REQ-005 Decode SHALL support ADD, SUB, AND, OR, XOR, NOR, SLT (op 000000, func 100000/100010/100100/100101/100110/100111/101010), ADDI 001000, ANDI 001100, ORI 001101, XORI 001110, SLTI 001010, LW 100011, SW 101011, BEQ 000100, BNE 000101.
REQ-006 ALUCode SHALL be: and 000, or 001, add 010, xor 011, nor 100, sub 110, slt 111; BEQ/BNE/SUB -> sub; LW/SW/ADDI -> add.
REQ-007 Controls: RegWrite = R-type|I-type ALU|LW; RegDst = R-type; ALUSrc_B = I-type ALU|LW|SW; MemRead = MemtoReg = LW; MemWrite = SW; Branch = BEQ|BNE; BranchNe = BNE.
REQ-008 inst == 0 SHALL decode as legal NOP (all controls 0, ex_illegal 0).
REQ-009 Any other encoding SHALL enter ID/EX with ex_valid 1, all controls 0, ALUCode add, ex_illegal 1 for exactly that stage occupancy.
REQ-010 ID/EX SHALL update every rising clk; latency inst -> ex_* is one cycle.
REQ-011 Load-use hazard (combinational): ex_valid & ex_MemRead & ex_rt != 0 & (ex_rt == inst[25:21] | (rt-source & ex_rt == inst[20:16])), rt-source = R-type|BEQ|BNE|SW; requires id_valid.
REQ-012 stall SHALL equal hazard & ~flush; on stall, ID/EX loads a bubble (ex_valid 0, all controls and ex_illegal 0).
REQ-013 flush SHALL have priority over stall and load a bubble; stall 0 that cycle.
REQ-014 id_valid 0 SHALL load a bubble; bubbles never raise stall in the following cycle.
REQ-015 ex_rs/ex_rt/ex_rd/ex_imm SHALL load inst fields only for non-bubble loads, otherwise zero.
REQ-016 Back-to-back LW then dependent instruction SHALL stall exactly one cycle.

Reset
REQ-017 With rst_n low at clk edge all ex_* outputs SHALL be 0, counters 0; stall SHALL be 0 while reset is asserted.
REQ-018 Reset mid-stall SHALL drop the pending bubble; first edge after release loads the current inst normally.

Configuration
REQ-019 Macro ID_EX_PERF_CNT_EN SHALL, when defined, add outputs stall_cnt  out  32 and flush_cnt  out  32, saturating at 32'hFFFFFFFF, incrementing once per cycle stall or flush is 1.
REQ-020 Without ID_EX_PERF_CNT_EN those ports and registers SHALL not exist; all other behaviour identical.

Structure
REQ-021 Opcode/func constants, ALUCode values and the control-bundle packed struct SHALL live in package ctrl_pkg.
REQ-022 Decode SHALL be a combinational sub-module ctrl_decode (inst -> bundle, illegal); id_ex_ctrl holds hazard logic, stage register, counters.

Verification
REQ-023 ADD $3,$1,$2 (0x00221820), id_valid 1 -> next cycle ex_RegWrite 1, ex_RegDst 1, ex_ALUCode 010, ex_rd 3.
REQ-024 LW $2,4($1) then ADD $3,$2,$4 -> stall 1 one cycle, one bubble, ADD enters following cycle; stall_cnt 1.
REQ-025 LW $2 then SW $2,0($5) -> stall 1 (rt-source); LW $0 then ADD $3,$0,$0 -> no stall.
REQ-026 Hazard and flush same cycle -> stall 0, bubble loaded, flush_cnt +1.
REQ-027 inst 0xFC000000 -> ex_valid 1, ex_illegal 1, all write controls 0; inst 0 -> ex_illegal 0.
REQ-028 Reset low during stall -> all ex_* 0, stall 0, counters 0; SLTI after release -> ex_ALUCode 111, ex_ALUSrc_B 1, ex_imm sign-extended.
